// File: rtl/key_event_pkg.sv
// Shared types and default keycodes for the key event unit.
package key_event_pkg;
    localparam int EV_W   = 2;
    localparam int NUM_EV = 4;

    typedef enum logic [EV_W-1:0] {EV_JUMP, EV_START, EV_LVL1, EV_LVL2} ev_code_t;

    // USB HID usage codes
    localparam logic [7:0] KC_JUMP  = 8'h2C;
    localparam logic [7:0] KC_START = 8'h28;
    localparam logic [7:0] KC_LVL1  = 8'h1E;
    localparam logic [7:0] KC_LVL2  = 8'h1F;
endpackage

// File: rtl/event_fifo.sv
// Small circular event queue with sticky overflow; a pop on the same cycle frees a slot for a push.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic                         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/key_event_unit.sv
// Frame-sampled, debounced keycode decoder feeding a small event queue.
// Define KEY_EVENT_REPEAT_EN to build the held-jump auto-repeat.
module key_event_unit
    import key_event_pkg::*;
#(
    parameter logic [7:0] KEY_JUMP        = KC_JUMP,
    parameter logic [7:0] KEY_START       = KC_START,
    parameter logic [7:0] KEY_LVL1        = KC_LVL1,
    parameter logic [7:0] KEY_LVL2        = KC_LVL2,
    parameter int         DEBOUNCE_FRAMES = 2,
    parameter int         REPEAT_DELAY    = 20,
    parameter int         REPEAT_PERIOD   = 8,
    parameter int         FIFO_DEPTH      = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic [7:0]        keycode,
    output logic              ev_valid,
    output logic [EV_W-1:0]   ev_code,
    input  logic              ev_ready,
    output logic [NUM_EV-1:0] key_held,
    output logic              overflow
);
    localparam logic [2:0] DB_CNT = 3'(DEBOUNCE_FRAMES);

    // [1:0] synchroniser, [2] previous synced level for edge detect
    logic [2:0] sync_pipe;
    logic       frame_tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) sync_pipe <= '1;
        else          sync_pipe <= {sync_pipe[1:0], frame_clk};
    end
    assign frame_tick = sync_pipe[1] & ~sync_pipe[2];

    logic [NUM_EV-1:0] match, prev, held_nxt, rise;
    logic [2:0]        stable_cnt, stable_nxt;
    logic              accept;

    assign match[EV_JUMP]  = (keycode == KEY_JUMP);
    assign match[EV_START] = (keycode == KEY_START);
    assign match[EV_LVL1]  = (keycode == KEY_LVL1);
    assign match[EV_LVL2]  = (keycode == KEY_LVL2);

    always_comb begin
        stable_nxt = 3'd1;
        if (match == prev)
            stable_nxt = (stable_cnt == 3'd7) ? 3'd7 : stable_cnt + 3'd1;
        // accept only on the tick where the count first lands on the threshold
        accept   = (stable_nxt == DB_CNT) && ((match != prev) || (stable_cnt != DB_CNT));
        held_nxt = accept ? match : key_held;
        rise     = held_nxt & ~key_held;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev       <= '0;
            stable_cnt <= '0;
            key_held   <= '0;
        end else if (frame_tick) begin
            prev       <= match;
            stable_cnt <= stable_nxt;
            key_held   <= held_nxt;
        end
    end

    logic rep_fire;
`ifdef KEY_EVENT_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [RW-1:0] rep_cnt, rep_nxt;

    // counter folds back to DELAY each period, so hitting DELAY marks every repeat
    always_comb begin
        rep_nxt = rep_cnt + 1'b1;
        if (rep_nxt == RW'(REPEAT_DELAY + REPEAT_PERIOD))
            rep_nxt = RW'(REPEAT_DELAY);
        rep_fire = key_held[EV_JUMP] & held_nxt[EV_JUMP] & (rep_nxt == RW'(REPEAT_DELAY));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)        rep_cnt <= '0;
        else if (frame_tick) rep_cnt <= (key_held[EV_JUMP] & held_nxt[EV_JUMP]) ? rep_nxt : '0;
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire   = 1'b0;
`endif

    // pending pushes drain lowest code first, one per cycle
    logic [NUM_EV-1:0] pend, pend_clr;
    logic              push;
    ev_code_t          push_code;

    always_comb begin
        push      = |pend;
        push_code = EV_JUMP;
        pend_clr  = '0;
        for (int i = NUM_EV-1; i >= 0; i--)
            if (pend[i]) push_code = ev_code_t'(i[EV_W-1:0]);
        pend_clr[push_code] = push;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            pend <= '0;
        else
            pend <= (pend & ~pend_clr)
                  | (frame_tick ? (rise | {{(NUM_EV-1){1'b0}}, rep_fire}) : '0);
    end

    logic fifo_full, fifo_empty;

    event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EV_W)) u_fifo (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (push),
        .push_data (push_code),
        .pop       (ev_ready),
        .head      (ev_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign ev_valid = ~fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_key_event_unit.sv
// Self-checking bench for key_event_unit: vector table, directed corner sequences, random vs model.
module tb_key_event_unit;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid, overflow;
    logic [1:0] ev_code;
    logic [3:0] key_held;

    int errors = 0;
    int checks = 0;

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam int DB = 2;

    always #10 Clk = ~Clk;

    key_event_unit dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_ready  (ev_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    initial begin
        repeat (60000) @(posedge Clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // reference model: key index 0..3, 4 = no event key
    int m_prev, m_run, m_held, m_hf;
    int mq[$];
    bit m_ovf;

    function automatic int key_idx(input logic [7:0] kc);
        case (kc)
            8'h2C:   return 0;
            8'h28:   return 1;
            8'h1E:   return 2;
            8'h1F:   return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_prev = 4; m_run = 0; m_held = 4; m_hf = 0; m_ovf = 0;
        mq.delete();
    endtask

    task automatic model_frame(input logic [7:0] kc, input bit pop);
        int m, old, ev;
        m = key_idx(kc);
        ev = -1;
        if (m == m_prev) begin
            if (m_run < 7) m_run++;
        end else begin
            m_prev = m;
            m_run = 1;
        end
        old = m_held;
        if (m_run == DB) m_held = m;
        if (m_held != old && m_held < 4) begin
            ev = m_held;
            m_hf = 0;
        end else if (REP && m_held == 0) begin
            m_hf++;
            if (m_hf >= 20 && (m_hf - 20) % 8 == 0) ev = 0;
        end
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (ev >= 0) begin
            if (mq.size() < 4) mq.push_back(ev);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_held"}, key_held, (m_held < 4) ? (32'd1 << m_held) : 32'd0);
        chk({tag, "_valid"}, ev_valid, (mq.size() > 0) ? 1 : 0);
        chk({tag, "_ovf"}, overflow, m_ovf);
        if (mq.size() > 0) chk({tag, "_code"}, ev_code, mq[0]);
    endtask

    // one video frame; ev_ready pulses on the cycle the frame's event is pushed
    task automatic run_frame(input logic [7:0] kc, input bit pop);
        @(negedge Clk);
        keycode = kc;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        ev_ready = pop;
        @(negedge Clk);
        ev_ready = 1'b0;
        repeat (4) @(negedge Clk);
        model_frame(kc, pop);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_clk = 1'b1;
        ev_ready = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic pop_expect(input logic [1:0] code);
        chk("drain_valid", ev_valid, 1);
        chk("drain_code", ev_code, code);
        ev_ready = 1'b1;
        @(negedge Clk);
        ev_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] kc;
        bit         pop;
        logic [3:0] held;
        bit         valid;
        logic [1:0] code;
        bit         ovf;
    } vec_t;

    vec_t tab[22];

    initial begin
        logic [7:0] kcs[6];
        logic [7:0] kc;
        bit exp_v;
        int nev;

        tab[0]  = '{8'h2C, 0, 4'b0000, 0, 2'd0, 0};
        tab[1]  = '{8'h2C, 0, 4'b0001, 1, 2'd0, 0};
        tab[2]  = '{8'h2C, 1, 4'b0001, 0, 2'd0, 0};
        tab[3]  = '{8'h00, 0, 4'b0001, 0, 2'd0, 0};
        tab[4]  = '{8'h00, 0, 4'b0000, 0, 2'd0, 0};
        tab[5]  = '{8'h28, 0, 4'b0000, 0, 2'd0, 0};
        tab[6]  = '{8'h00, 0, 4'b0000, 0, 2'd0, 0};
        tab[7]  = '{8'h00, 0, 4'b0000, 0, 2'd0, 0};
        tab[8]  = '{8'h28, 0, 4'b0000, 0, 2'd0, 0};
        tab[9]  = '{8'h28, 0, 4'b0010, 1, 2'd1, 0};
        tab[10] = '{8'h1E, 0, 4'b0010, 1, 2'd1, 0};
        tab[11] = '{8'h1E, 0, 4'b0100, 1, 2'd1, 0};
        tab[12] = '{8'h1F, 0, 4'b0100, 1, 2'd1, 0};
        tab[13] = '{8'h1F, 0, 4'b1000, 1, 2'd1, 0};
        tab[14] = '{8'h28, 0, 4'b1000, 1, 2'd1, 0};
        tab[15] = '{8'h28, 0, 4'b0010, 1, 2'd1, 0};
        tab[16] = '{8'h1E, 0, 4'b0010, 1, 2'd1, 0};
        tab[17] = '{8'h1E, 0, 4'b0100, 1, 2'd1, 1};
        tab[18] = '{8'h1E, 1, 4'b0100, 1, 2'd2, 1};
        tab[19] = '{8'h1E, 1, 4'b0100, 1, 2'd3, 1};
        tab[20] = '{8'h1E, 1, 4'b0100, 1, 2'd1, 1};
        tab[21] = '{8'h1E, 1, 4'b0100, 0, 2'd0, 1};

        // reset state
        repeat (2) @(negedge Clk);
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_held", key_held, 0);
        chk("rst_ovf", overflow, 0);
        Reset_n = 1'b1;
        model_reset();

        // press, pop, release, glitch, overflow and drain
        for (int i = 0; i < 22; i++) begin
            run_frame(tab[i].kc, tab[i].pop);
            chk($sformatf("vec%0d_held", i), key_held, tab[i].held);
            chk($sformatf("vec%0d_valid", i), ev_valid, tab[i].valid);
            chk($sformatf("vec%0d_ovf", i), overflow, tab[i].ovf);
            if (tab[i].valid) chk($sformatf("vec%0d_code", i), ev_code, tab[i].code);
        end

        // full queue with a pop landing on the push cycle
        do_reset();
        run_frame(8'h28, 0); run_frame(8'h28, 0);
        run_frame(8'h1E, 0); run_frame(8'h1E, 0);
        run_frame(8'h1F, 0); run_frame(8'h1F, 0);
        run_frame(8'h28, 0); run_frame(8'h28, 0);
        run_frame(8'h1E, 0); run_frame(8'h1E, 1);
        chk("fullpp_ovf", overflow, 0);
        pop_expect(2'd2);
        pop_expect(2'd3);
        pop_expect(2'd1);
        pop_expect(2'd2);
        chk("fullpp_empty", ev_valid, 0);
        chk("fullpp_ovf2", overflow, 0);

        // async reset mid-hold, key stays down across it
        do_reset();
        run_frame(8'h28, 0); run_frame(8'h28, 0);
        run_frame(8'h2C, 0); run_frame(8'h2C, 0);
        chk("midrst_pre_held", key_held, 4'b0001);
        chk("midrst_pre_code", ev_code, 1);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("midrst_valid", ev_valid, 0);
        chk("midrst_code", ev_code, 0);
        chk("midrst_held", key_held, 0);
        chk("midrst_ovf", overflow, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        run_frame(8'h2C, 0);
        chk("midrst_f1_held", key_held, 0);
        chk("midrst_f1_valid", ev_valid, 0);
        run_frame(8'h2C, 0);
        chk("midrst_f2_held", key_held, 4'b0001);
        chk("midrst_f2_valid", ev_valid, 1);
        chk("midrst_f2_code", ev_code, 0);
        run_frame(8'h2C, 1);
        chk("midrst_f3_valid", ev_valid, 0);

        // long jump hold with the consumer always ready
        do_reset();
        nev = 0;
        for (int i = 1; i <= 40; i++) begin
            run_frame(8'h2C, 1);
            exp_v = (i == 2) || (REP && (i == 22 || i == 30 || i == 38));
            chk($sformatf("rep%0d_valid", i), ev_valid, exp_v);
            if (exp_v) chk($sformatf("rep%0d_code", i), ev_code, 0);
            if (ev_valid) nev++;
        end
        chk("rep_count", nev, REP ? 4 : 1);

        // random keys and consumer against the model
        kcs[0] = 8'h2C; kcs[1] = 8'h28; kcs[2] = 8'h1E;
        kcs[3] = 8'h1F; kcs[4] = 8'h00; kcs[5] = 8'h55;
        do_reset();
        kc = 8'h00;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) kc = kcs[$urandom_range(0, 5)];
            run_frame(kc, $urandom_range(0, 2) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
